strob_seq: RTL and testbench
============================

// Module: strob_seq
// PURPOSE
//  Timing/state sequencer directly upstream of the P-M microinstruction unit.
//  Holds the one-hot major-state register (K1,K2,P0..P5,I1..I5) and drives the per-state phase
//  sequence ST1 -> [memory wait] -> [ST2] -> GOT as active-low strob1_/strob2_/got_.
//  At each GOT end it loads the next major state selected by the enter requests
//  (ek1,ek2,ep0..ep5,ei1..ei5) that P-M and the interrupt unit compute.
// PARAMETERS
//  STROB_TICKS  3     clocks per ST1, ST2 and GOT phase (>=1)
//  MEM_TICKS    255   clocks in memory wait before alarm (>=1, counter 8 bit)
// PORTS
//  __clk     in   1   system clock
//  clm_      in   1   master clear, asynchronous, active-low
//  ek1,ek2   in   1   enter K1/K2 request (panel states)
//  ep0..ep5  in   1   enter P0..P5 request
//  ei1..ei5  in   1   enter I1..I5 request (interrupt entry sequence)
//  sts       in   1   current state needs two strobes (ST2 executed when 1)
//  mem_req   in   1   current state performs memory access; wait for ok_ after ST1
//  ok_       in   1   memory answer, active-low, sampled on __clk
//  hold      in   1   freeze sequencer at start of next ST1 (STOP/WAIT from P-M)
//  strob1_,strob2_,got_  out 1  phase strobes, active-low, registered
//  k1_,k2_,p0_..p5_,i1_..i5_  out 1  major-state outputs, active-low, one-hot, registered
//  alarm     out  1   memory no-answer flag, sticky until clm_
// BEHAVIOUR
//  - Reset (clm_=0, async): state=P0 (p0_=0, all other state outputs 1), phase=IDLE,
//    strob1_=strob2_=got_=1, alarm=0, timers cleared. clm_ mid-phase aborts immediately.
//  - Phases: IDLE, ST1, MW, ST2, GOT. Phase timer counts STROB_TICKS clocks per ST1/ST2/GOT.
//  - IDLE: if hold=1 stay; else -> ST1 next clock. First cycle after reset starts from IDLE.
//  - ST1: strob1_=0 for exactly STROB_TICKS clocks. At its last clock, sample mem_req, sts:
//    mem_req=1 -> MW; else sts=1 -> ST2; else -> GOT.
//  - MW: all strobes 1. ok_=0 sampled -> ST2 if sts else GOT (next clock).
//    Wait counter reaching MEM_TICKS without ok_ -> alarm=1, -> GOT (state sequence continues;
//    P-M handles the alarm). ok_ during ST1 is ignored.
//  - ST2: strob2_=0 for STROB_TICKS clocks, then -> GOT.
//  - GOT: got_=0 for STROB_TICKS clocks. On its last clock the state register loads the
//    next state; then -> IDLE if hold=1, else straight to ST1 (no idle gap).
//  - Next-state select, fixed priority: ek1>ek2>ep0>ei1..ei5>ep1..ep5 (lower index first).
//    No request asserted -> state unchanged. Several asserted -> highest wins, no error.
//  - Requests and sts/mem_req are sampled only at the decision clocks above; levels between
//    are don't-care.
//  - Strobe outputs mutually exclusive; never two of strob1_,strob2_,got_ low same clock.
//  - State outputs change only at GOT end, so they are stable across all strobes of a cycle.
//  - Latency: minimum cycle (no mem, sts=0) = 2*STROB_TICKS clocks; with ST2 = 3*STROB_TICKS.
//  - hold asserted during a cycle does not truncate it; takes effect after GOT.
// STRUCTURE
//  - Shared header strob_seq_defs.vh: localparams for phase encoding (IDLE..GOT) and
//    one-hot state-bit indices (K1..I5), reused by the P-M wrapper and bench.
//  - One sub-module: phase_timer (load/count/terminal-count, width from parameter), used
//    for both the strobe-length and memory-wait counters.
//  - Top: phase FSM, priority encoder, state register, registered active-low outputs.
// TESTING
//  - Reset: clm_=0 mid-ST2 -> next sample p0_=0, strob*_=got_=1, alarm=0, phase IDLE.
//  - STROB_TICKS=2, sts=0, mem_req=0, ep1=1: strob1_ low clks 1-2, got_ low 3-4, p1_=0 at clk 5.
//  - sts=1, mem_req=1, ok_ low 5 clks after ST1: strob1_ 2 clks, 5 idle, strob2_ 2, got_ 2.
//  - MEM_TICKS=4, ok_ stuck 1 -> alarm=1 after 4 wait clks, got_ follows, alarm held to clm_.
//  - ep3=ei2=ek2=1 at GOT end -> k2_=0 only; no requests -> state unchanged.
//  - hold=1 during ST1 -> cycle completes, sequencer parks IDLE; hold=0 -> ST1 next clock.

Source files
------------

// File: rtl/strob_seq_pkg.sv
// Shared definitions for the strobe sequencer: phase encoding, one-hot state-bit
// indices and the next-state priority selector.
package strob_seq_pkg;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_ST1  = 3'd1,
    PH_MW   = 3'd2,
    PH_ST2  = 3'd3,
    PH_GOT  = 3'd4
  } phase_t;

  localparam int NUM_STATES = 13;

  localparam int K1 = 0;
  localparam int K2 = 1;
  localparam int P0 = 2;
  localparam int P1 = 3;
  localparam int P2 = 4;
  localparam int P3 = 5;
  localparam int P4 = 6;
  localparam int P5 = 7;
  localparam int I1 = 8;
  localparam int I2 = 9;
  localparam int I3 = 10;
  localparam int I4 = 11;
  localparam int I5 = 12;

  typedef logic [NUM_STATES-1:0] state_vec_t;

  function automatic state_vec_t state_bit(input int idx);
    return state_vec_t'(1) << idx;
  endfunction

  // Fixed priority: K1 > K2 > P0 > I1..I5 > P1..P5; no request keeps the current state.
  function automatic state_vec_t select_next(input state_vec_t req, input state_vec_t cur);
    state_vec_t nxt;
    nxt = cur;
    if      (req[K1]) nxt = state_bit(K1);
    else if (req[K2]) nxt = state_bit(K2);
    else if (req[P0]) nxt = state_bit(P0);
    else if (req[I1]) nxt = state_bit(I1);
    else if (req[I2]) nxt = state_bit(I2);
    else if (req[I3]) nxt = state_bit(I3);
    else if (req[I4]) nxt = state_bit(I4);
    else if (req[I5]) nxt = state_bit(I5);
    else if (req[P1]) nxt = state_bit(P1);
    else if (req[P2]) nxt = state_bit(P2);
    else if (req[P3]) nxt = state_bit(P3);
    else if (req[P4]) nxt = state_bit(P4);
    else if (req[P5]) nxt = state_bit(P5);
    return nxt;
  endfunction

endpackage

// File: rtl/strob_seq_if.sv
// Signal bundle between the strobe sequencer (slave) and the P-M / interrupt
// logic that supplies enter requests and consumes strobes and major states (master).
interface strob_seq_if;
  logic ek1, ek2;
  logic ep0, ep1, ep2, ep3, ep4, ep5;
  logic ei1, ei2, ei3, ei4, ei5;
  logic sts, mem_req, ok_, hold;
  logic strob1_, strob2_, got_;
  logic k1_, k2_;
  logic p0_, p1_, p2_, p3_, p4_, p5_;
  logic i1_, i2_, i3_, i4_, i5_;
  logic alarm;

  modport master (
    output ek1, ek2, ep0, ep1, ep2, ep3, ep4, ep5, ei1, ei2, ei3, ei4, ei5,
    output sts, mem_req, ok_, hold,
    input  strob1_, strob2_, got_,
    input  k1_, k2_, p0_, p1_, p2_, p3_, p4_, p5_, i1_, i2_, i3_, i4_, i5_,
    input  alarm
  );

  modport slave (
    input  ek1, ek2, ep0, ep1, ep2, ep3, ep4, ep5, ei1, ei2, ei3, ei4, ei5,
    input  sts, mem_req, ok_, hold,
    output strob1_, strob2_, got_,
    output k1_, k2_, p0_, p1_, p2_, p3_, p4_, p5_, i1_, i2_, i3_, i4_, i5_,
    output alarm
  );
endinterface

// File: rtl/strob_seq_phase_timer.sv
// Clearable up-counter with terminal count, used for strobe lengths and the
// memory-wait timeout.
module phase_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] last,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  // load restarts the phase from zero; it wins over counting so the terminal
  // clock of one phase leaves the counter ready for the next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = en && (count == last);

endmodule

// File: rtl/strob_seq.sv
// Major-state register and ST1 -> [MW] -> [ST2] -> GOT phase sequencer feeding
// the P-M microinstruction unit.
module strob_seq
  import strob_seq_pkg::*;
#(
  parameter int STROB_TICKS = 3,
  parameter int MEM_TICKS   = 255
) (
  input  logic       __clk,
  input  logic       clm_,
  strob_seq_if.slave bus
);

  localparam int SW = $clog2(STROB_TICKS + 1);
  localparam logic [SW-1:0] STROB_LAST = SW'(STROB_TICKS - 1);
  localparam logic [7:0]    MEM_LAST   = 8'(MEM_TICKS - 1);
  localparam state_vec_t    RESET_STATE = state_bit(P0);

  phase_t     phase;
  phase_t     phase_nxt;
  state_vec_t state_n;
  state_vec_t req;
  logic       need_st2;
  logic       strob1_r, strob2_r, got_r, alarm_r;
  logic       strob_en, strob_tc, mem_en, mem_load, mem_tc;

  assign req = {bus.ei5, bus.ei4, bus.ei3, bus.ei2, bus.ei1,
                bus.ep5, bus.ep4, bus.ep3, bus.ep2, bus.ep1, bus.ep0,
                bus.ek2, bus.ek1};

  assign strob_en = (phase == PH_ST1) || (phase == PH_ST2) || (phase == PH_GOT);
  assign mem_en   = (phase == PH_MW);
  assign mem_load = !mem_en || !bus.ok_ || mem_tc;

  phase_timer #(.WIDTH(SW)) u_strob_timer (
    .clk   (__clk),
    .rst_n (clm_),
    .load  (strob_tc || !strob_en),
    .en    (strob_en),
    .last  (STROB_LAST),
    .tc    (strob_tc)
  );

  phase_timer #(.WIDTH(8)) u_mem_timer (
    .clk   (__clk),
    .rst_n (clm_),
    .load  (mem_load),
    .en    (mem_en),
    .last  (MEM_LAST),
    .tc    (mem_tc)
  );

  // An answer on the last wait clock beats the timeout.
  always_comb begin
    phase_nxt = phase;
    case (phase)
      PH_IDLE: if (!bus.hold) phase_nxt = PH_ST1;
      PH_ST1:  if (strob_tc)  phase_nxt = bus.mem_req ? PH_MW : (bus.sts ? PH_ST2 : PH_GOT);
      PH_MW: begin
        if (!bus.ok_)       phase_nxt = need_st2 ? PH_ST2 : PH_GOT;
        else if (mem_tc)    phase_nxt = PH_GOT;
      end
      PH_ST2:  if (strob_tc)  phase_nxt = PH_GOT;
      PH_GOT:  if (strob_tc)  phase_nxt = bus.hold ? PH_IDLE : PH_ST1;
      default:                phase_nxt = PH_IDLE;
    endcase
  end

  always_ff @(posedge __clk or negedge clm_) begin
    if (!clm_) begin
      phase    <= PH_IDLE;
      state_n  <= ~RESET_STATE;
      need_st2 <= 1'b0;
      strob1_r <= 1'b1;
      strob2_r <= 1'b1;
      got_r    <= 1'b1;
      alarm_r  <= 1'b0;
    end else begin
      phase    <= phase_nxt;
      strob1_r <= (phase_nxt != PH_ST1);
      strob2_r <= (phase_nxt != PH_ST2);
      got_r    <= (phase_nxt != PH_GOT);
      if (phase == PH_ST1 && strob_tc) begin
        need_st2 <= bus.sts;
      end
      if (phase == PH_MW && bus.ok_ && mem_tc) begin
        alarm_r <= 1'b1;
      end
      if (phase == PH_GOT && strob_tc) begin
        state_n <= ~select_next(req, ~state_n);
      end
    end
  end

  assign bus.strob1_ = strob1_r;
  assign bus.strob2_ = strob2_r;
  assign bus.got_    = got_r;
  assign bus.alarm   = alarm_r;

  assign bus.k1_ = state_n[K1];
  assign bus.k2_ = state_n[K2];
  assign bus.p0_ = state_n[P0];
  assign bus.p1_ = state_n[P1];
  assign bus.p2_ = state_n[P2];
  assign bus.p3_ = state_n[P3];
  assign bus.p4_ = state_n[P4];
  assign bus.p5_ = state_n[P5];
  assign bus.i1_ = state_n[I1];
  assign bus.i2_ = state_n[I2];
  assign bus.i3_ = state_n[I3];
  assign bus.i4_ = state_n[I4];
  assign bus.i5_ = state_n[I5];

endmodule

// File: tb/tb_strob_seq.sv
// Self-checking bench for strob_seq: a duration-based cycle model predicts every
// clock's strobes, state and alarm, and a few literal points pin the model.
module tb_strob_seq;
  import strob_seq_pkg::*;

  localparam int ST = 2;
  localparam int MT = 4;

  localparam int B_S1 = 16;
  localparam int B_S2 = 15;
  localparam int B_G  = 14;
  localparam int B_AL = 0;

  typedef logic [16:0] vec_t;

  logic __clk = 1'b0;
  logic clm_;

  strob_seq_if bus ();

  strob_seq #(.STROB_TICKS(ST), .MEM_TICKS(MT)) dut (
    .__clk (__clk),
    .clm_  (clm_),
    .bus   (bus)
  );

  always #5 __clk = ~__clk;

  vec_t dut_now;
  assign dut_now = {bus.strob1_, bus.strob2_, bus.got_,
                    bus.i5_, bus.i4_, bus.i3_, bus.i2_, bus.i1_,
                    bus.p5_, bus.p4_, bus.p3_, bus.p2_, bus.p1_, bus.p0_,
                    bus.k2_, bus.k1_, bus.alarm};

  int   total = 0;
  int   bad   = 0;
  int   exp_state;
  logic exp_alarm;
  vec_t exp_q [$];
  vec_t trace [$];
  vec_t exp_now;

  // Compare process: one expected vector per clock, checked mid-period.
  always @(negedge __clk) begin
    if (exp_q.size() > 0) begin
      exp_now = exp_q.pop_front();
      trace.push_back(dut_now);
      total++;
      if (dut_now !== exp_now) begin
        bad++;
        $display("[TB] FAIL clk%0d vec: got=%h want=%h", trace.size() - 1, dut_now, exp_now);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not finish");
    $fatal(1, "[TB] timeout");
  end

  // Priority rank from the request rules: K1,K2,P0 first, then I1..I5, then P1..P5.
  function automatic int rank(input int idx);
    if (idx <= P0) return idx;
    if (idx >= I1) return idx - I1 + 3;
    return idx - P1 + 8;
  endfunction

  function automatic int pick(input logic [12:0] r, input int cur);
    int best;
    int best_rank;
    logic [12:0] s;
    best = cur;
    best_rank = 99;
    for (int i = 0; i < 13; i++) begin
      s = r >> i;
      if (s[0] && rank(i) < best_rank) begin
        best_rank = rank(i);
        best = i;
      end
    end
    return best;
  endfunction

  task automatic next_clk();
    @(posedge __clk);
    #2;
  endtask

  task automatic push(input logic s1, input logic s2, input logic g);
    exp_q.push_back({s1, s2, g, ~(13'd1 << exp_state), exp_alarm});
  endtask

  task automatic set_req(input logic [12:0] r);
    {bus.ei5, bus.ei4, bus.ei3, bus.ei2, bus.ei1,
     bus.ep5, bus.ep4, bus.ep3, bus.ep2, bus.ep1, bus.ep0,
     bus.ek2, bus.ek1} = r;
  endtask

  task automatic do_reset();
    next_clk();
    clm_ = 1'b0;
    exp_state = P0;
    exp_alarm = 1'b0;
    push(1'b1, 1'b1, 1'b1);
    next_clk();
    clm_ = 1'b1;
    bus.hold = 1'b0;
    push(1'b1, 1'b1, 1'b1);
  endtask

  // One full bus cycle: ST1, optional memory wait, optional ST2, GOT.
  // ok_at = wait clock on which ok_ is answered (0 = never); abort_at = clock index for clm_.
  task automatic apply_cycle(input logic sts_i, input logic mem_i, input int ok_at,
                             input logic ok_in_st1, input logic [12:0] req_i,
                             input logic hold_i, input int abort_at);
    int w;
    int n2;
    int len;
    logic timeout;
    w = 0;
    timeout = 1'b0;
    if (mem_i) begin
      if (ok_at >= 1 && ok_at <= MT) w = ok_at;
      else begin
        w = MT;
        timeout = 1'b1;
      end
    end
    n2 = (sts_i && !timeout) ? ST : 0;
    len = ST + w + n2 + ST;
    for (int k = 0; k < len; k++) begin
      next_clk();
      if (k == 0) begin
        bus.sts = sts_i;
        bus.mem_req = mem_i;
        bus.hold = hold_i;
        set_req(req_i);
      end
      if (k == abort_at) begin
        clm_ = 1'b0;
        exp_state = P0;
        exp_alarm = 1'b0;
        push(1'b1, 1'b1, 1'b1);
        return;
      end
      bus.ok_ = 1'b1;
      if (k < ST && ok_in_st1) bus.ok_ = 1'b0;
      if (mem_i && !timeout && k == ST + w - 1) bus.ok_ = 1'b0;
      if (timeout && k == ST + w) exp_alarm = 1'b1;
      if (k < ST)               push(1'b0, 1'b1, 1'b1);
      else if (k < ST + w)      push(1'b1, 1'b1, 1'b1);
      else if (k < ST + w + n2) push(1'b1, 1'b0, 1'b1);
      else                      push(1'b1, 1'b1, 1'b0);
    end
    exp_state = pick(req_i, exp_state);
  endtask

  task automatic park(input int n);
    for (int k = 0; k < n; k++) begin
      next_clk();
      bus.hold = (k < n - 1);
      push(1'b1, 1'b1, 1'b1);
    end
  endtask

  task automatic release_reset();
    next_clk();
    clm_ = 1'b1;
    bus.hold = 1'b0;
    push(1'b1, 1'b1, 1'b1);
  endtask

  task automatic check_output(input string name, input int idx, input int bitpos, input logic want);
    vec_t v;
    vec_t s;
    total++;
    if (idx >= trace.size()) begin
      bad++;
      $display("[TB] FAIL %s: clk%0d not recorded, want=%b", name, idx, want);
    end else begin
      v = trace[idx];
      s = v >> bitpos;
      if (s[0] !== want) begin
        bad++;
        $display("[TB] FAIL %s: got=%b want=%b", name, s[0], want);
      end
    end
  endtask

  localparam logic [12:0] R_NONE = 13'd0;
  localparam logic [12:0] R_EP1  = 13'd1 << P1;
  localparam logic [12:0] R_MIX  = (13'd1 << P3) | (13'd1 << I2) | (13'd1 << K2);
  localparam logic [12:0] R_IP   = (13'd1 << I2) | (13'd1 << P3);
  localparam logic [12:0] R_I5P5 = (13'd1 << I5) | (13'd1 << P5);
  localparam logic [12:0] R_EK1  = 13'd1 << K1;

  initial begin
    clm_ = 1'b0;
    bus.sts = 1'b0;
    bus.mem_req = 1'b0;
    bus.ok_ = 1'b1;
    bus.hold = 1'b0;
    set_req(R_NONE);
    exp_state = P0;
    exp_alarm = 1'b0;

    do_reset();
    apply_cycle(1'b0, 1'b0, 0, 1'b0, R_EP1,  1'b0, -1);
    apply_cycle(1'b1, 1'b1, 3, 1'b0, R_NONE, 1'b0, -1);
    apply_cycle(1'b0, 1'b1, MT, 1'b0, R_MIX, 1'b0, -1);
    apply_cycle(1'b1, 1'b1, 0, 1'b1, R_IP,   1'b0, -1);
    apply_cycle(1'b0, 1'b0, 0, 1'b0, R_NONE, 1'b1, -1);
    park(3);
    apply_cycle(1'b0, 1'b0, 0, 1'b0, R_I5P5, 1'b0, -1);
    apply_cycle(1'b1, 1'b0, 0, 1'b0, R_EK1,  1'b0, 3);
    release_reset();
    apply_cycle(1'b0, 1'b0, 0, 1'b0, R_EK1,  1'b0, -1);
    apply_cycle(1'b0, 1'b0, 0, 1'b0, R_NONE, 1'b0, -1);
    @(negedge __clk);
    #1;

    check_output("rst_p0",      0,  1 + P0, 1'b0);
    check_output("rst_alarm",   0,  B_AL,   1'b0);
    check_output("a_s1_clk1",   2,  B_S1,   1'b0);
    check_output("a_s1_clk2",   3,  B_S1,   1'b0);
    check_output("a_s1_off",    4,  B_S1,   1'b1);
    check_output("a_got_clk3",  4,  B_G,    1'b0);
    check_output("a_got_clk4",  5,  B_G,    1'b0);
    check_output("a_p0_stable", 5,  1 + P0, 1'b0);
    check_output("a_p1_clk5",   6,  1 + P1, 1'b0);
    check_output("b_mw_s1",     10, B_S1,   1'b1);
    check_output("b_mw_s2",     10, B_S2,   1'b1);
    check_output("b_s2_a",      11, B_S2,   1'b0);
    check_output("b_s2_b",      12, B_S2,   1'b0);
    check_output("b_got",       13, B_G,    1'b0);
    check_output("c_no_alarm",  22, B_AL,   1'b0);
    check_output("c_k2",        23, 1 + K2, 1'b0);
    check_output("c_p3_off",    23, 1 + P3, 1'b1);
    check_output("d_pre_alarm", 28, B_AL,   1'b0);
    check_output("d_alarm",     29, B_AL,   1'b1);
    check_output("d_got",       29, B_G,    1'b0);
    check_output("d_i2",        31, 1 + I2, 1'b0);
    check_output("e_idle_s1",   35, B_S1,   1'b1);
    check_output("e_idle_got",  35, B_G,    1'b1);
    check_output("e_alarm_hld", 37, B_AL,   1'b1);
    check_output("f_i5",        42, 1 + I5, 1'b0);
    check_output("g_st2",       44, B_S2,   1'b0);
    check_output("g_rst_s2",    45, B_S2,   1'b1);
    check_output("g_rst_p0",    45, 1 + P0, 1'b0);
    check_output("g_rst_alarm", 45, B_AL,   1'b0);
    check_output("h_k1",        51, 1 + K1, 1'b0);
    check_output("i_k1_kept",   54, 1 + K1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
